// File: rtl/data_bus_pkg.sv
// Shared constants for the data bus responder: default address map, peripheral
// word offsets and TCON bit positions.
package data_bus_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h4000_0000;
  localparam int unsigned RAM_WORDS_DEFAULT   = 256;

  // Word offsets inside the 32-byte peripheral page (byte offset >> 2).
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LEDS    = 3'd3;
  localparam logic [2:0] OFF_DIGITS  = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_STATUS = 2;

  localparam int TCON_W   = 3;
  localparam int LEDS_W   = 8;
  localparam int DIGITS_W = 12;

endpackage

// File: rtl/bus_timer.sv
// Reloading timer (TH/TL/TCON) with a level interrupt; compiled only when
// DATA_BUS_TIMER_EN is defined.
`ifdef DATA_BUS_TIMER_EN
module bus_timer
  import data_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic              irq_q, irq_d;

  // NOTE: every signal driven here gets a default first and uses blocking '='; a missing default would infer a latch.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IRQ_EN]) tcon_d[TCON_STATUS] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    // A CPU write replaces the timer update for its register; a TL write also
    // cancels the reload event, so no status is raised on that edge.
    if (wr_en) begin
      case (offset)
        OFF_TH:   th_d = wdata;
        OFF_TL: begin
          tl_d   = wdata;
          tcon_d = tcon_q;
        end
        OFF_TCON: tcon_d = wdata[TCON_W-1:0];
        default: ;
      endcase
    end

    irq_d = tcon_d[TCON_IRQ_EN] & tcon_d[TCON_STATUS];
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:   rdata = th_q;
      OFF_TL:   rdata = tl_q;
      OFF_TCON: rdata = 32'(tcon_q);
      default:  rdata = '0;
    endcase
  end

  // NOTE: state flops use non-blocking '<=' so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
`endif

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM plus peripheral page (LEDs, digits, SYSTICK and,
// with DATA_BUS_TIMER_EN defined, the bus_timer block). Reads are combinational.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = RAM_WORDS_DEFAULT,
  parameter logic [31:0] RAM_BASE    = RAM_BASE_DEFAULT,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0]         ram_off;
  logic                ram_hit;
  logic [RAM_AW-1:0]   ram_idx;
  logic                periph_hit;
  logic [2:0]          periph_off;
  logic                periph_we;
  logic [31:0]         rd_data;
  logic [31:0]         timer_rdata;
  logic                timer_irq;
  logic                unused_bits;

  logic [31:0]         ram_q [RAM_WORDS];
  logic [LEDS_W-1:0]   leds_q, leds_d;
  logic [DIGITS_W-1:0] digits_q, digits_d;
  logic [31:0]         systick_q, systick_d;

  // Offset subtraction wraps addresses below RAM_BASE to large values, so one
  // unsigned compare covers both ends of the RAM window.
  always_comb begin
    ram_off    = MemBus_Address - RAM_BASE;
    ram_hit    = ({1'b0, ram_off} < RAM_BYTES);
    ram_idx    = ram_off[RAM_AW+1:2];
    periph_hit = (MemBus_Address[31:5] == PERIPH_BASE[31:5]);
    periph_off = MemBus_Address[4:2];
    periph_we  = MemWrite && periph_hit;
  end

  assign unused_bits = ^ram_off[1:0];

  always_comb begin
    leds_d    = leds_q;
    digits_d  = digits_q;
    systick_d = systick_q + 32'd1;
    if (periph_we) begin
      case (periph_off)
        OFF_LEDS:   leds_d   = MemBus_Write_Data[LEDS_W-1:0];
        OFF_DIGITS: digits_d = MemBus_Write_Data[DIGITS_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q    <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      leds_q    <= leds_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  // NOTE: the RAM array has no reset term; reset only blocks writes so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && ram_hit) ram_q[ram_idx] <= MemBus_Write_Data;
  end

`ifdef DATA_BUS_TIMER_EN
  bus_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (periph_we),
    .offset (periph_off),
    .wdata  (MemBus_Write_Data),
    .rdata  (timer_rdata),
    .irq    (timer_irq)
  );
`else
  assign timer_rdata = '0;
  assign timer_irq   = 1'b0;
`endif

  // Read data reflects pre-edge state, so a combined read/write returns the old word.
  always_comb begin
    rd_data = '0;
    if (MemRead) begin
      if (ram_hit) begin
        rd_data = ram_q[ram_idx];
      end else if (periph_hit) begin
        case (periph_off)
          OFF_TH, OFF_TL, OFF_TCON: rd_data = timer_rdata;
          OFF_LEDS:                 rd_data = 32'(leds_q);
          OFF_DIGITS:               rd_data = 32'(digits_q);
          OFF_SYSTICK:              rd_data = systick_q;
          default:                  rd_data = '0;
        endcase
      end
    end
  end

  assign Device_Read_Data = rd_data;
  assign leds             = leds_q;
  assign digits           = digits_q;
  assign irq              = timer_irq;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: stimulus pushes expected samples,
// a negedge monitor pops and compares them. Timer checks follow DATA_BUS_TIMER_EN.
`timescale 1ns/1ps
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  logic        obs_req;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] tick_model = '0;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LEDS = 32'h4000_000C;
  localparam logic [31:0] A_DIG  = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_irq;
    logic        exp_irq;
    bit          chk_out;
    logic [7:0]  exp_leds;
    logic [11:0] exp_digits;
  } exp_t;

  exp_t exp_q[$];

  data_bus_responder dut (
    .clk               (clk),
    .reset             (reset),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemBus_Address    (MemBus_Address),
    .MemBus_Write_Data (MemBus_Write_Data),
    .Device_Read_Data  (Device_Read_Data),
    .leds              (leds),
    .digits            (digits),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  // Free-running cycle count since reset, used only for SYSTICK expectations.
  always @(posedge clk) tick_model <= reset ? 32'd0 : tick_model + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a read or an observation request consumes one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (MemRead === 1'b1 || obs_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: got a sample, expected none queued");
        end else begin
          e = exp_q.pop_front();
          if (e.chk_rd)  check({e.name, "/rdata"}, Device_Read_Data, e.exp_rd);
          if (e.chk_irq) check({e.name, "/irq"}, 32'(irq), 32'(e.exp_irq));
          if (e.chk_out) begin
            check({e.name, "/leds"}, 32'(leds), 32'(e.exp_leds));
            check({e.name, "/digits"}, 32'(digits), 32'(e.exp_digits));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t blank(input string name);
    exp_t e;
    e.name = name;
    e.chk_rd = 1'b0;  e.exp_rd = '0;
    e.chk_irq = 1'b0; e.exp_irq = 1'b0;
    e.chk_out = 1'b0; e.exp_leds = '0; e.exp_digits = '0;
    return e;
  endfunction

  task automatic issue(input exp_t e, input bit rd_en, input logic [31:0] addr);
    exp_q.push_back(e);
    MemBus_Address = addr;
    MemRead = rd_en;
    obs_req = !rd_en;
    @(posedge clk); #1;
    MemRead = 1'b0;
    obs_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemBus_Address = addr;
    MemBus_Write_Data = data;
    MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e = blank(name);
    e.chk_rd = 1'b1; e.exp_rd = exp;
    issue(e, 1'b1, addr);
  endtask

  task automatic rd_irq(input logic [31:0] addr, input logic [31:0] exp, input logic ei, input string name);
    exp_t e = blank(name);
    e.chk_rd = 1'b1; e.exp_rd = exp;
    e.chk_irq = 1'b1; e.exp_irq = ei;
    issue(e, 1'b1, addr);
  endtask

  // No read strobe: read data must be zero whatever the address.
  task automatic obs_irq(input logic ei, input string name);
    exp_t e = blank(name);
    e.chk_rd = 1'b1; e.exp_rd = '0;
    e.chk_irq = 1'b1; e.exp_irq = ei;
    issue(e, 1'b0, MemBus_Address);
  endtask

  task automatic obs_out(input logic [7:0] l, input logic [11:0] d, input string name);
    exp_t e = blank(name);
    e.chk_out = 1'b1; e.exp_leds = l; e.exp_digits = d;
    issue(e, 1'b0, MemBus_Address);
  endtask

  task automatic rw(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp, input string name);
    exp_t e = blank(name);
    e.chk_rd = 1'b1; e.exp_rd = exp;
    exp_q.push_back(e);
    MemBus_Address = addr;
    MemBus_Write_Data = data;
    MemRead = 1'b1;
    MemWrite = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic reset_with_write(input logic [31:0] addr, input logic [31:0] data);
    reset = 1'b1;
    MemBus_Address = addr;
    MemBus_Write_Data = data;
    MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    obs_req = 1'b0;
    MemBus_Address = '0;
    MemBus_Write_Data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(A_TICK, 32'd0, "systick_after_reset");
    rd(A_TICK, 32'd1, "systick_counts");
    rd(A_TH, 32'd0, "th_reset");
    rd(A_TL, 32'd0, "tl_reset");
    rd(A_TCON, 32'd0, "tcon_reset");
    rd(A_LEDS, 32'd0, "leds_reg_reset");
    obs_out(8'h00, 12'h000, "outs_reset");
    obs_irq(1'b0, "irq_reset");

    // RAM round trip and window edges
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd_0x10");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd_0x13");
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_03FC, 32'hCAFE_F00D);
    rd(32'h0000_03FC, 32'hCAFE_F00D, "ram_last_word");
    rd(32'h0000_0400, 32'h0000_0000, "ram_past_end");
    rd(32'h0000_0000, 32'h1111_1111, "ram_word0");
    obs_irq(1'b0, "no_read_strobe");
    wr(32'h0000_0030, 32'h0000_1234);
    wr(32'h0000_0020, 32'h0000_1111);
    rw(32'h0000_0020, 32'h0000_2222, 32'h0000_1111, "rw_returns_old");
    rd(32'h0000_0020, 32'h0000_2222, "rw_write_done");

    // LEDs and digits
    wr(A_LEDS, 32'h0000_01A5);
    obs_out(8'hA5, 12'h000, "leds_written");
    wr(A_DIG, 32'h000F_FFFF);
    obs_out(8'hA5, 12'hFFF, "digits_written");
    rd(A_LEDS, 32'h0000_00A5, "leds_readback");
    rd(A_DIG, 32'h0000_0FFF, "digits_readback");

    // Unmapped space and read-only SYSTICK
    wr(32'h4000_002C, 32'h0000_0077);
    wr(32'h4000_0020, 32'h0000_0055);
    wr(32'h4000_001C, 32'h0000_0099);
    rd(A_LEDS, 32'h0000_00A5, "no_alias_next_page");
    rd(A_TH, 32'h0000_0000, "th_no_alias");
    rd(32'h4000_0018, 32'h0000_0000, "unmapped_0x18");
    rd(32'h4000_001C, 32'h0000_0000, "unmapped_0x1C");
    rd(32'h8000_0000, 32'h0000_0000, "unmapped_high");
    wr(A_TICK, 32'h0000_0000);
    rd(A_TICK, tick_model, "systick_write_ignored");

`ifdef DATA_BUS_TIMER_EN
    // Reload sequence
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TCON, 32'h0000_0003);
    rd_irq(A_TL, 32'hFFFF_FFFC, 1'b0, "tl_fc");
    rd_irq(A_TL, 32'hFFFF_FFFD, 1'b0, "tl_fd");
    rd_irq(A_TL, 32'hFFFF_FFFE, 1'b0, "tl_fe");
    rd_irq(A_TL, 32'hFFFF_FFFF, 1'b0, "tl_ff");
    rd_irq(A_TL, 32'hFFFF_FFFC, 1'b1, "tl_reload");
    rd_irq(A_TCON, 32'h0000_0007, 1'b1, "tcon_status_set");
    wr(A_TCON, 32'h0000_0003);
    rd_irq(A_TCON, 32'h0000_0003, 1'b0, "irq_cleared");

    // Freeze, then TL write colliding with the overflow reload
    wr(A_TCON, 32'h0000_0000);
    wr(A_TL, 32'hFFFF_FFFF);
    rd(A_TL, 32'hFFFF_FFFF, "tl_frozen_a");
    rd(A_TL, 32'hFFFF_FFFF, "tl_frozen_b");
    wr(A_TCON, 32'h0000_0003);
    wr(A_TL, 32'h0000_0005);
    rd_irq(A_TL, 32'h0000_0005, 1'b0, "collision_tl");
    rd_irq(A_TCON, 32'h0000_0003, 1'b0, "collision_tcon");

    // Get irq high before the mid-count reset
    wr(A_TCON, 32'h0000_0000);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h0000_0003);
    obs_irq(1'b0, "irq_pre_a");
    obs_irq(1'b0, "irq_pre_b");
    obs_irq(1'b1, "irq_before_reset");
`else
    wr(A_TCON, 32'h0000_0007);
    wr(A_TH, 32'h1234_5678);
    rd(A_TCON, 32'h0000_0000, "tcon_absent");
    rd(A_TH, 32'h0000_0000, "th_absent");
    for (int i = 0; i < 100; i++) obs_irq(1'b0, "irq_tied_low");
`endif

    // Mid-operation reset discards concurrent writes
    reset_with_write(A_LEDS, 32'h0000_00FF);
    reset_with_write(32'h0000_0030, 32'h0000_9999);
    rd_irq(A_TICK, 32'h0000_0000, 1'b0, "systick_restart");
    rd(A_TCON, 32'h0000_0000, "tcon_after_reset");
    rd(A_TL, 32'h0000_0000, "tl_after_reset");
    rd(A_TH, 32'h0000_0000, "th_after_reset");
    obs_out(8'h00, 12'h000, "outs_after_reset");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_reset");
    rd(32'h0000_0030, 32'h0000_1234, "ram_write_in_reset_ignored");

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
